// File: rtl/rv32_pkg.sv
// rv32_pkg: shared arbiter states, RV32 load/store size codes and the fetch NOP.
package rv32_pkg;
  typedef enum logic [1:0] {IDLE, FETCH, DATA} state_t;
  localparam logic [2:0] F3_B = 3'b000, F3_H = 3'b001, F3_W = 3'b010, F3_BU = 3'b100, F3_HU = 3'b101;
  localparam logic [31:0] NOP = 32'h0000_0013;
  function automatic logic lane_ok(input logic [2:0] f3, input logic [1:0] lo);
    return f3 == F3_B || f3 == F3_BU || ((f3 == F3_H || f3 == F3_HU) && !lo[0]) || (f3 == F3_W && lo == 2'b00);
  endfunction
endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: byte-lane enables, store shifting and load extraction/extension.
module mem_lane_align
  import rv32_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_sh,
  output logic [31:0] rdata_ext
);
  logic [15:0] sh;
  logic half, sgn;
  always_comb begin
    sh = 16'(rdata >> {addr_lo, 3'b000});
    half = funct3 == F3_H || funct3 == F3_HU;
    sgn = funct3 == F3_B || funct3 == F3_H;
    be = funct3 == F3_W ? 4'b1111 : half ? 4'b0011 << addr_lo : 4'b0001 << addr_lo;
    wdata_sh = wdata << {addr_lo, 3'b000};
    rdata_ext = funct3 == F3_W ? rdata : half ? {{16{sgn & sh[15]}}, sh} : {{24{sgn & sh[7]}}, sh[7:0]};
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one registered memory port between instruction fetch and data access.
module mem_port_arbiter
  import rv32_pkg::*;
#(
  parameter int TIMEOUT_CYC = 16,
  parameter int STARVE_LIM  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  input  logic        if_flush,
  output logic        if_valid,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [2:0]  d_funct3,
  output logic        d_valid,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam int SW = $clog2(STARVE_LIM + 1);
  state_t state, state_n;
  logic [SW-1:0] starve_cnt;
  logic [TW-1:0] tmo_cnt;
  logic discard, idle_free, d_bad, d_ok, f_ok, grant_d, grant_f, done;
  logic [2:0] op_f3;
  logic [1:0] op_lo;
  logic [3:0] be;
  logic [31:0] wdata_sh, rdata_ext;
  logic unused_if_lo;
  assign unused_if_lo = ^if_addr[1:0];
  // No grant in a valid-pulse cycle: the requester is still holding the request it just got answered.
  assign idle_free = state == IDLE && !d_valid && !if_valid;
  assign d_bad = !lane_ok(d_funct3, d_addr[1:0]);
  assign d_ok = idle_free && d_req && !d_bad;
  assign f_ok = idle_free && if_req && !if_flush;
  assign grant_f = f_ok && (!d_ok || starve_cnt == SW'(STARVE_LIM));
  assign grant_d = d_ok && !grant_f;
  assign done = state != IDLE && (mem_ack || tmo_cnt == TW'(TIMEOUT_CYC - 1));
  mem_lane_align u_align (
    .funct3   (state == IDLE ? d_funct3 : op_f3),
    .addr_lo  (state == IDLE ? d_addr[1:0] : op_lo),
    .wdata    (d_wdata),
    .rdata    (mem_rdata),
    .be       (be),
    .wdata_sh (wdata_sh),
    .rdata_ext(rdata_ext)
  );
  always_comb begin
    state_n = state;
    if (grant_d) state_n = DATA;
    else if (grant_f) state_n = FETCH;
    else if (done) state_n = IDLE;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt <= '0;
      tmo_cnt <= '0;
      discard <= 1'b0;
      op_f3 <= '0;
      op_lo <= '0;
      mem_req <= 1'b0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      mem_be <= '0;
      if_valid <= 1'b0;
      if_rdata <= '0;
      d_valid <= 1'b0;
      d_rdata <= '0;
      d_err <= 1'b0;
    end else begin
      if_valid <= 1'b0;
      d_valid <= 1'b0;
      d_err <= 1'b0;
      if (grant_d || grant_f) begin
        mem_req <= 1'b1;
        mem_we <= grant_d && d_we;
        mem_addr <= {grant_d ? d_addr[31:2] : if_addr[31:2], 2'b00};
        mem_wdata <= grant_d ? wdata_sh : '0;
        mem_be <= grant_d ? be : 4'b1111;
        tmo_cnt <= '0;
        discard <= 1'b0;
      end else if (state != IDLE) tmo_cnt <= tmo_cnt + TW'(1);
      if (grant_d) begin
        op_f3 <= d_funct3;
        op_lo <= d_addr[1:0];
      end
      if (grant_f) starve_cnt <= '0;
      else if (grant_d && if_req && starve_cnt != SW'(STARVE_LIM)) starve_cnt <= starve_cnt + SW'(1);
      if (idle_free && d_req && d_bad) begin
        d_valid <= 1'b1;
        d_err <= 1'b1;
      end
      if (state == FETCH && if_flush) discard <= 1'b1;
      if (done) begin
        mem_req <= 1'b0;
        mem_we <= 1'b0;
        mem_addr <= '0;
        mem_wdata <= '0;
        mem_be <= '0;
        discard <= 1'b0;
        if (state == DATA) begin
          d_valid <= 1'b1;
          d_err <= !mem_ack;
          d_rdata <= mem_ack ? rdata_ext : '0;
        end else if (!(discard || if_flush)) begin
          if_valid <= 1'b1;
          if_rdata <= mem_ack ? mem_rdata : NOP;
        end
      end
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed stimulus with queued expectations checked by an output monitor.
module tb_mem_port_arbiter;
  import rv32_pkg::*;
  typedef struct { logic we; logic [31:0] addr; logic [31:0] wdata; logic [3:0] be; } mem_t;
  typedef struct { logic err; logic cmp_rd; logic [31:0] rdata; } d_t;
  logic clk = 1'b0, rst = 1'b0;
  logic if_req = 1'b0, if_flush = 1'b0, d_req = 1'b0, d_we = 1'b0, mem_ack = 1'b0;
  logic [31:0] if_addr = '0, d_addr = '0, d_wdata = '0, mem_rdata = '0;
  logic [2:0] d_funct3 = '0;
  logic if_valid, d_valid, d_err, mem_req, mem_we;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
  logic [3:0] mem_be;
  mem_t exp_mem[$];
  d_t exp_d[$];
  logic [31:0] exp_i[$];
  mem_t em;
  d_t ed;
  logic [31:0] ei;
  int checks = 0, errors = 0, ack_dly = 0, run_len = 0, last_len = 0, wcnt = 0, n_o = 0, fcnt = 0;
  logic ack_en = 1'b1, prev_req = 1'b0;
  logic [31:0] rd_word = '0;

  always #5 clk = ~clk;

  mem_port_arbiter dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush), .if_valid(if_valid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_funct3(d_funct3),
    .d_valid(d_valid), .d_rdata(d_rdata), .d_err(d_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // memory model: ack ack_dly cycles after mem_req appears
  initial forever begin
    @(posedge clk); #1;
    if (mem_req && ack_en && !mem_ack) begin
      if (wcnt == ack_dly) begin
        mem_ack = 1'b1;
        mem_rdata = rd_word;
        wcnt = 0;
      end else wcnt++;
    end else begin
      mem_ack = 1'b0;
      wcnt = 0;
    end
  end

  initial forever begin
    @(negedge clk);
    if (mem_req && !prev_req) begin
      if (exp_mem.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL mem_unexpected actual=req@%h required=none", mem_addr);
      end else begin
        em = exp_mem.pop_front();
        chk("mem_we", 32'(mem_we), 32'(em.we));
        chk("mem_addr", mem_addr, em.addr);
        chk("mem_be", 32'(mem_be), 32'(em.be));
        if (em.we) chk("mem_wdata", mem_wdata, em.wdata);
      end
    end
    if (mem_req) run_len++;
    else if (run_len != 0) begin
      last_len = run_len;
      run_len = 0;
    end
    prev_req = mem_req;
    if (d_valid) begin
      if (exp_d.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL d_unexpected actual=valid required=none rdata=%h", d_rdata);
      end else begin
        ed = exp_d.pop_front();
        chk("d_err", 32'(d_err), 32'(ed.err));
        if (ed.cmp_rd) chk("d_rdata", d_rdata, ed.rdata);
      end
    end
    if (if_valid) begin
      if (exp_i.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL if_unexpected actual=valid required=none rdata=%h", if_rdata);
      end else begin
        ei = exp_i.pop_front();
        chk("if_rdata", if_rdata, ei);
      end
    end
  end

  task automatic data_op(input string nm, input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [2:0] f3, input logic [31:0] rd, input int dly, input logic use_mem,
                         input logic [3:0] be, input logic [31:0] mwd, input logic err,
                         input logic [31:0] erd, input int lat);
    int n = 0;
    rd_word = rd;
    ack_dly = dly;
    if (use_mem) exp_mem.push_back('{we, {addr[31:2], 2'b00}, mwd, be});
    exp_d.push_back('{err, !err && !we, erd});
    @(posedge clk); #1;
    d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata; d_funct3 = f3;
    do begin
      @(negedge clk);
      n++;
    end while (!d_valid && n < 100);
    chk({nm, "_latency"}, 32'(n), 32'(lat));
    @(posedge clk); #1;
    d_req = 1'b0;
  endtask

  task automatic fetch_op(input string nm, input logic [31:0] addr, input logic [31:0] rd, input int dly,
                          input logic [31:0] erd, input int lat);
    int n = 0;
    rd_word = rd;
    ack_dly = dly;
    exp_mem.push_back('{1'b0, {addr[31:2], 2'b00}, 32'h0, 4'hf});
    exp_i.push_back(erd);
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = addr;
    do begin
      @(negedge clk);
      n++;
    end while (!if_valid && n < 100);
    chk({nm, "_latency"}, 32'(n), 32'(lat));
    @(posedge clk); #1;
    if_req = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_mem_ctl", 32'({mem_req, mem_we, mem_be}), 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_valids", 32'({if_valid, d_valid, d_err}), 32'h0);
    chk("rst_rdata", if_rdata | d_rdata, 32'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    rd_word = 32'h1234_5678;
    ack_dly = 0;
    for (int i = 0; i < 10; i++) begin
      if (i % 5 == 4) begin
        exp_mem.push_back('{1'b0, 32'h1000, 32'h0, 4'hf});
        exp_i.push_back(32'h1234_5678);
      end else begin
        exp_mem.push_back('{1'b0, 32'h200, 32'h0, 4'hf});
        exp_d.push_back('{1'b0, 1'b1, 32'h1234_5678});
      end
    end
    if_req = 1'b1; if_addr = 32'h1000;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200; d_funct3 = F3_W;
    while (fcnt < 2 && n_o < 300) begin
      @(negedge clk);
      n_o++;
      if (if_valid) fcnt++;
    end
    chk("order_fetches", 32'(fcnt), 32'd2);
    @(posedge clk); #1;
    if_req = 1'b0; d_req = 1'b0;
    chk("order_mem_left", 32'(exp_mem.size()), 32'd0);
    chk("order_d_left", 32'(exp_d.size()), 32'd0);

    data_op("lw", 1'b0, 32'h100, '0, F3_W, 32'hDEAD_BEEF, 2, 1'b1, 4'hf, '0, 1'b0, 32'hDEAD_BEEF, 5);
    chk("lw_req_len", 32'(last_len), 32'd3);
    data_op("lb", 1'b0, 32'h103, '0, F3_B, 32'h80FF_FFFF, 1, 1'b1, 4'b1000, '0, 1'b0, 32'hFFFF_FF80, 4);
    data_op("lbu", 1'b0, 32'h103, '0, F3_BU, 32'h80FF_FFFF, 1, 1'b1, 4'b1000, '0, 1'b0, 32'h0000_0080, 4);
    data_op("lh", 1'b0, 32'h102, '0, F3_H, 32'h8001_1234, 0, 1'b1, 4'b1100, '0, 1'b0, 32'hFFFF_8001, 3);
    data_op("lhu", 1'b0, 32'h102, '0, F3_HU, 32'h8001_1234, 0, 1'b1, 4'b1100, '0, 1'b0, 32'h0000_8001, 3);
    data_op("sw", 1'b1, 32'h104, 32'hCAFE_F00D, F3_W, '0, 0, 1'b1, 4'hf, 32'hCAFE_F00D, 1'b0, '0, 3);
    data_op("sb", 1'b1, 32'h101, 32'h0000_005A, F3_B, '0, 0, 1'b1, 4'b0010, 32'h0000_5A00, 1'b0, '0, 3);
    data_op("sh", 1'b1, 32'h102, 32'h0000_ABCD, F3_H, '0, 0, 1'b1, 4'b1100, 32'hABCD_0000, 1'b0, '0, 3);
    data_op("sw_mis", 1'b1, 32'h102, 32'h1, F3_W, '0, 0, 1'b0, '0, '0, 1'b1, '0, 2);
    data_op("lh_mis", 1'b0, 32'h101, '0, F3_H, '0, 0, 1'b0, '0, '0, 1'b1, '0, 2);
    data_op("f3_bad", 1'b0, 32'h100, '0, 3'b011, '0, 0, 1'b0, '0, '0, 1'b1, '0, 2);
    ack_en = 1'b0;
    data_op("d_tmo", 1'b0, 32'h300, '0, F3_W, '0, 0, 1'b1, 4'hf, '0, 1'b1, '0, 18);
    chk("d_tmo_req_len", 32'(last_len), 32'd16);
    fetch_op("f_tmo", 32'h700, '0, 0, NOP, 18);
    ack_en = 1'b1;

    exp_mem.push_back('{1'b0, 32'h400, 32'h0, 4'hf});
    ack_dly = 3;
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = 32'h400;
    @(posedge clk); #1;
    if_flush = 1'b1; if_req = 1'b0;
    @(posedge clk); #1;
    if_flush = 1'b0;
    repeat (8) @(posedge clk);
    chk("flush_mem_done", 32'(exp_mem.size()), 32'd0);
    fetch_op("refetch", 32'h500, 32'h00A0_0093, 1, 32'h00A0_0093, 4);

    @(posedge clk); #1;
    if_req = 1'b1; if_addr = 32'h800; if_flush = 1'b1;
    @(posedge clk); #1;
    if_req = 1'b0; if_flush = 1'b0;
    @(negedge clk);
    chk("flush_idle_block", 32'(mem_req), 32'h0);

    data_op("lw2", 1'b0, 32'h104, '0, F3_W, 32'h55AA_55AA, 0, 1'b1, 4'hf, '0, 1'b0, 32'h55AA_55AA, 3);
    ack_en = 1'b0;
    exp_mem.push_back('{1'b0, 32'h600, 32'h0, 4'hf});
    @(posedge clk); #1;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h600; d_funct3 = F3_W;
    repeat (3) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk("arst_mem_req", 32'(mem_req), 32'h0);
    chk("arst_mem_addr", mem_addr, 32'h0);
    chk("arst_mem_be", 32'(mem_be), 32'h0);
    chk("arst_valids", 32'({d_valid, d_err, if_valid}), 32'h0);
    chk("arst_d_rdata", d_rdata, 32'h0);
    chk("arst_if_rdata", if_rdata, 32'h0);
    d_req = 1'b0;
    ack_en = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    repeat (4) @(negedge clk);
    fetch_op("post_rst", 32'h900, 32'h0010_0073, 0, 32'h0010_0073, 3);

    chk("left_mem", 32'(exp_mem.size()), 32'd0);
    chk("left_d", 32'(exp_d.size()), 32'd0);
    chk("left_i", 32'(exp_i.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  TIMEOUT_CYC  16  cycles without mem_ack before an access aborts
  STARVE_LIM   4   consecutive data grants while fetch waits before fetch is forced
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
  clk        in   1   single clock, rising edge
  rst        in   1   asynchronous, active-low reset
  if_req     in   1   fetch request, held until if_valid
  if_addr    in   32  fetch word address
  if_flush   in   1   cancel the outstanding fetch (branch/jump redirect)
  if_valid   out  1   one-cycle pulse, if_rdata valid
  if_rdata   out  32  fetched instruction
  d_req      in   1   data request, held until d_valid
  d_we       in   1   1=store, 0=load
  d_addr     in   32  byte address
  d_wdata    in   32  store data, LSB-aligned
  d_funct3   in   3   RV32 size/sign code: 000 B, 001 H, 010 W, 100 BU, 101 HU
  d_valid    out  1   one-cycle pulse, access complete
  d_rdata    out  32  load data, extended per d_funct3
  d_err      out  1   qualifies d_valid: misaligned access or timeout
  mem_req    out  1   shared single-port memory request, registered
  mem_we     out  1   memory write enable
  mem_addr   out  32  word-aligned address ({addr[31:2],2'b00})
  mem_wdata  out  32  lane-shifted store data
  mem_be     out  4   byte enables
  mem_ack    in   1   memory completion; mem_rdata valid in the same cycle
  mem_rdata  in   32  memory read word

Function
REQ-003 The FSM SHALL have exactly three states: IDLE, FETCH, DATA.
REQ-004 In IDLE: d_req with an aligned address SHALL move to DATA; otherwise if_req (and no if_flush) SHALL move to FETCH; if neither is present, the FSM SHALL stay in IDLE.
REQ-005 When both requests are present, data SHALL win, except when starve_cnt == STARVE_LIM; then fetch SHALL win and starve_cnt SHALL clear.
REQ-006 starve_cnt SHALL increment on each DATA grant taken while if_req is high, clear on each FETCH grant, and saturate at STARVE_LIM.
REQ-007 mem_req/mem_we/mem_addr/mem_wdata/mem_be SHALL be registered: valid from the first cycle in FETCH/DATA, held stable until mem_ack, and low/zero in IDLE.
REQ-008 On mem_ack the FSM SHALL return to IDLE, and the matching valid SHALL pulse for exactly one cycle on the next cycle with registered rdata; minimum spacing between accesses is 3 cycles.
REQ-009 Byte enables: B = 4'b0001<<addr[1:0]; H = 4'b0011<<addr[1:0]; W = 4'b1111. mem_wdata SHALL shift by 8*addr[1:0]. Fetch SHALL drive mem_we=0, mem_be=4'b1111.
REQ-010 Load data SHALL be shifted right by 8*addr[1:0], then sign-extended (B, H) or zero-extended (BU, HU); W passes through unchanged.
REQ-011 Misaligned accesses (H with addr[0]=1; W with addr[1:0]!=0) and illegal funct3 values SHALL issue no memory cycle; d_valid and d_err SHALL pulse on the cycle after the request is sampled in IDLE.
REQ-012 A timeout counter SHALL reset on entry to FETCH/DATA. At TIMEOUT_CYC cycles without mem_ack: drop mem_req, return to IDLE, and pulse the valid (with d_err=1 for data; fetch returns rdata 32'h00000013).
REQ-013 if_flush while in FETCH SHALL set a discard flag. The eventual ack still completes the memory cycle, but if_valid SHALL be suppressed. if_flush in IDLE SHALL block a fetch grant that cycle.
REQ-014 mem_ack in IDLE SHALL be ignored.

Reset
REQ-015 rst low SHALL asynchronously force state IDLE and clear starve_cnt, the timeout counter, and the discard flag. All outputs SHALL be 0.
REQ-016 A reset asserted during an access SHALL abandon it with no valid pulse. After reset release, arbitration SHALL restart from IDLE.

Structure
REQ-017 State encodings, funct3 size codes, and the NOP constant 32'h00000013 SHALL live in a shared package (rv32_pkg).
REQ-018 Lane alignment and extension (REQ-009/010) SHALL be one combinational sub-module, mem_lane_align. The FSM and counters SHALL stay in the top level.

Verification
REQ-019 Load word: d_req, addr 0x100, funct3 010, mem_ack 2 cycles after mem_req -> mem_addr 0x100, be 1111; d_rdata 0xDEADBEEF, one-cycle d_valid.
REQ-020 Signed byte load: addr 0x103, funct3 000, mem_rdata 0x80FFFFFF -> be 1000, d_rdata 0xFFFFFF80. Same with funct3 100 -> 0x00000080.
REQ-021 if_req and d_req both held continuously -> grant order D,D,D,D,F,D,D,D,D,F.
REQ-022 Misaligned SW to 0x102 -> no mem_req; d_valid and d_err pulse on the next cycle.
REQ-023 Fetch issued, if_flush during FETCH, ack 3 cycles later -> no if_valid. A following fetch is granted from IDLE.
REQ-024 mem_ack never arrives -> mem_req drops after 16 cycles with d_err=1. Reset asserted mid-DATA -> all outputs 0 asynchronously, with no valid pulse.
